// File: rtl/flip_sched_pkg.sv
// flip_sched_pkg: lane-state type, parameter defaults and clog2 helper
package flip_sched_pkg;
  typedef enum logic [1:0] {INIT, HAVE0, HAVE1} lane_st_e;
  localparam int NLANE_DEF = 4;
  localparam int CNT_W_DEF = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/flip_detect_sched_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requesting lane at or after ptr
module rr_arbiter
  import flip_sched_pkg::*;
#(
  parameter int N  = NLANE_DEF,
  parameter int LW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic          found;
  logic [LW:0]   s;
  logic [LW-1:0] idx;
  always_comb begin
    gnt = '0;
    found = 1'b0;
    s = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      s = {1'b0, ptr} + (LW+1)'(i);
      idx = (s >= (LW+1)'(N)) ? LW'(s - (LW+1)'(N)) : s[LW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/flip_detect_sched.sv
// flip_detect_sched: round-robin serial lanes, per-lane bit-flip detection and saturating counters
module flip_detect_sched
  import flip_sched_pkg::*;
#(
  parameter  int NLANE = NLANE_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int LW    = clog2(NLANE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NLANE-1:0] req,
  input  logic [NLANE-1:0] ser_in,
  input  logic             clr_cnt,
  input  logic [LW-1:0]    cnt_sel,
  output logic [NLANE-1:0] gnt,
  output logic             det_vld,
  output logic             det,
  output logic [LW-1:0]    det_lane,
  output logic [CNT_W-1:0] cnt_out
);
  logic [LW-1:0]    ptr_q, ptr_d, lane_q, lane_d, k;
  logic [NLANE-1:0] arb_gnt;
  lane_st_e         st_q [NLANE], st_d [NLANE];
  logic [CNT_W-1:0] cnt_q [NLANE], cnt_d [NLANE];
  logic             vld_q, vld_d, det_q, det_d, hit, b;
  rr_arbiter #(.N(NLANE), .LW(LW)) u_arb (.req(req), .ptr(ptr_q), .gnt(arb_gnt));
  assign gnt = (rst && !clr_cnt) ? arb_gnt : '0;
  assign hit = |gnt;
  always_comb begin
    k = '0;
    for (int i = 0; i < NLANE; i++) if (gnt[i]) k = LW'(i);
  end
  assign ptr_d = !hit ? ptr_q : (k == LW'(NLANE - 1)) ? '0 : k + LW'(1);
  assign b = ser_in[k];
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    det_d = 1'b0;
    vld_d = hit;
    lane_d = hit ? k : lane_q;
    if (clr_cnt) begin
      st_d = '{default: INIT};
      cnt_d = '{default: '0};
    end else if (hit) begin
      st_d[k] = b ? HAVE1 : HAVE0;
      det_d = (st_q[k] != INIT) && (b != (st_q[k] == HAVE1));
      if (det_d && cnt_q[k] != '1) cnt_d[k] = cnt_q[k] + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      st_q <= '{default: INIT};
      cnt_q <= '{default: '0};
      vld_q <= 1'b0;
      det_q <= 1'b0;
      lane_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      st_q <= st_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      det_q <= det_d;
      lane_q <= lane_d;
    end
  end
  assign det_vld = vld_q;
  assign det = det_q;
  assign det_lane = lane_q;
  // reads see the registered count, so a same-cycle increment is not yet visible
  assign cnt_out = (int'(cnt_sel) < NLANE) ? cnt_q[cnt_sel] : '0;
endmodule

// File: tb/tb_flip_detect_sched.sv
// tb_flip_detect_sched: directed vector table plus reset, saturation and async-reset sequences
module tb_flip_detect_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0, ser_in = '0;
  logic       clr_cnt = 1'b0;
  logic [1:0] cnt_sel = '0;
  logic [3:0] gnt, gnt_s;
  logic       det_vld, det, vld_s, det_s;
  logic [1:0] det_lane, lane_s;
  logic [7:0] cnt_out;
  logic [1:0] cnt_s;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  flip_detect_sched u_dut (.clk(clk), .rst(rst), .req(req), .ser_in(ser_in), .clr_cnt(clr_cnt),
    .cnt_sel(cnt_sel), .gnt(gnt), .det_vld(det_vld), .det(det), .det_lane(det_lane), .cnt_out(cnt_out));
  flip_detect_sched #(.NLANE(4), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .req(req), .ser_in(ser_in),
    .clr_cnt(clr_cnt), .cnt_sel(cnt_sel), .gnt(gnt_s), .det_vld(vld_s), .det(det_s), .det_lane(lane_s),
    .cnt_out(cnt_s));

  typedef struct {
    logic [3:0] req, ser; logic clr; logic [1:0] sel;
    logic [3:0] gnt; logic vld, det; logic [1:0] lane; logic [7:0] cnt;
  } vec_t;
  vec_t tv [32];
  int nv = 0;

  task automatic add(input logic [3:0] r, s, input logic c, input logic [1:0] sl,
                     input logic [3:0] g, input logic v, d, input logic [1:0] l, input logic [7:0] n);
    tv[nv] = '{r, s, c, sl, g, v, d, l, n};
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // fairness from ptr=0, then 1010 pattern from ptr=0
    add(4'b1111, 4'b0000, 0, 0, 4'b0001, 1, 0, 0, 0);
    add(4'b1111, 4'b0000, 0, 0, 4'b0010, 1, 0, 1, 0);
    add(4'b1111, 4'b0000, 0, 0, 4'b0100, 1, 0, 2, 0);
    add(4'b1111, 4'b0000, 0, 0, 4'b1000, 1, 0, 3, 0);
    add(4'b1111, 4'b0000, 0, 0, 4'b0001, 1, 0, 0, 0);
    add(4'b1000, 4'b0000, 0, 0, 4'b1000, 1, 0, 3, 0);
    add(4'b1010, 4'b1111, 0, 1, 4'b0010, 1, 1, 1, 0);
    add(4'b1010, 4'b1111, 0, 1, 4'b1000, 1, 1, 3, 1);
    add(4'b1010, 4'b1111, 0, 3, 4'b0010, 1, 0, 1, 1);
    add(4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 0, 1, 1);
    // lane 0 alone, bits 0,1,1,0,0
    add(4'b0001, 4'b0000, 0, 0, 4'b0001, 1, 0, 0, 0);
    add(4'b0001, 4'b0001, 0, 0, 4'b0001, 1, 1, 0, 0);
    add(4'b0001, 4'b0001, 0, 0, 4'b0001, 1, 0, 0, 1);
    add(4'b0001, 4'b0000, 0, 0, 4'b0001, 1, 1, 0, 1);
    add(4'b0001, 4'b0000, 0, 0, 4'b0001, 1, 0, 0, 2);
    add(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 2);
    // lane 1 to count 3, clear with request held, then bits 1,0
    add(4'b0010, 4'b0000, 0, 1, 4'b0010, 1, 0, 1, 0);
    add(4'b0010, 4'b0010, 0, 1, 4'b0010, 1, 1, 1, 0);
    add(4'b0010, 4'b0000, 0, 1, 4'b0010, 1, 1, 1, 1);
    add(4'b0010, 4'b0010, 0, 1, 4'b0010, 1, 1, 1, 2);
    add(4'b0010, 4'b0000, 1, 1, 4'b0000, 0, 0, 1, 3);
    add(4'b0010, 4'b0010, 0, 1, 4'b0010, 1, 0, 1, 0);
    add(4'b0010, 4'b0000, 0, 1, 4'b0010, 1, 1, 1, 0);
    add(4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 0, 1, 1);

    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_vld", 32'(det_vld), 0);
    chk("rst_det", 32'(det), 0);
    chk("rst_lane", 32'(det_lane), 0);
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1 chk("rst_cnt", 32'(cnt_out), 0);
    end

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < nv; i++) begin
      if (i > 0) @(negedge clk);
      req = tv[i].req; ser_in = tv[i].ser; clr_cnt = tv[i].clr; cnt_sel = tv[i].sel;
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tv[i].gnt));
      chk($sformatf("v%0d_cnt", i), 32'(cnt_out), 32'(tv[i].cnt));
      @(posedge clk); #1;
      chk($sformatf("v%0d_vld", i), 32'(det_vld), 32'(tv[i].vld));
      chk($sformatf("v%0d_det", i), 32'(det), 32'(tv[i].det));
      chk($sformatf("v%0d_lane", i), 32'(det_lane), 32'(tv[i].lane));
    end

    // lane 2 alternating 0,1 for 8 grants: 7 flips, 2-bit counter saturates at 3
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req = 4'b0100; ser_in = (i % 2 == 1) ? 4'b0100 : 4'b0000; clr_cnt = 1'b0; cnt_sel = 2'd2;
      @(posedge clk); #1;
      chk("sat_det", 32'(det), (i > 0) ? 1 : 0);
      chk("sat_lane", 32'(det_lane), 2);
    end
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("sat_cnt2", 32'(cnt_s), 3);
    chk("sat_cnt8", 32'(cnt_out), 7);

    // async reset between edges on lane 3 with history
    @(negedge clk);
    req = 4'b1000; ser_in = 4'b0000; cnt_sel = 2'd3;
    @(posedge clk); #1;
    chk("ar_first_det", 32'(det), 0);
    @(negedge clk);
    ser_in = 4'b1000;
    @(posedge clk); #1;
    chk("ar_flip_vld", 32'(det_vld), 1);
    chk("ar_flip_det", 32'(det), 1);
    chk("ar_flip_lane", 32'(det_lane), 3);
    #2 rst = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 0);
    chk("ar_vld", 32'(det_vld), 0);
    chk("ar_det", 32'(det), 0);
    chk("ar_lane", 32'(det_lane), 0);
    chk("ar_cnt", 32'(cnt_out), 0);
    @(posedge clk); #1;
    chk("ar_hold_vld", 32'(det_vld), 0);
    @(negedge clk);
    rst = 1'b1; ser_in = 4'b0000;
    #1 chk("ar_rel_gnt", 32'(gnt), 32'(4'b1000));
    @(posedge clk); #1;
    chk("ar_rel_vld", 32'(det_vld), 1);
    chk("ar_rel_det", 32'(det), 0);
    chk("ar_rel_lane", 32'(det_lane), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
